// File: rtl/inst_mem_if.sv
// rtl/inst_mem_if.sv - load stream and fetch port bundle for inst_mem
//
// Groups the program-load stream, load status and fetch port of inst_mem.
//   master : program loader / fetch stage side (drives LoadStart, LoadValid,
//            LoadData, LoadLast, FetchEn, InstAddress)
//   slave  : the memory itself (drives LoadReady, Loaded, LoadCount, LoadErr,
//            InstOut, InstValid)
// Parameters A (address width) and W (instruction width) must match the memory.
interface inst_mem_if #(
    parameter int A = 10,
    parameter int W = 9
);
    logic           LoadStart;
    logic           LoadValid;
    logic [W-1:0]   LoadData;
    logic           LoadLast;
    logic           LoadReady;
    logic           Loaded;
    logic [A:0]     LoadCount;
    logic           LoadErr;
    logic           FetchEn;
    logic [A-1:0]   InstAddress;
    logic [W-1:0]   InstOut;
    logic           InstValid;

    modport master (
        output LoadStart, LoadValid, LoadData, LoadLast, FetchEn, InstAddress,
        input  LoadReady, Loaded, LoadCount, LoadErr, InstOut, InstValid
    );

    modport slave (
        input  LoadStart, LoadValid, LoadData, LoadLast, FetchEn, InstAddress,
        output LoadReady, Loaded, LoadCount, LoadErr, InstOut, InstValid
    );
endinterface

// File: rtl/inst_mem.sv
// rtl/inst_mem.sv - run-time loadable instruction memory with registered fetch port
//
// 2**A words of W bits. A program is streamed in over a valid/ready load port,
// then read by the fetch stage with one cycle of latency. Addresses at or
// beyond the loaded program length read as HALT_WORD.
// Ports:
//   Clk    : clock, all state changes on the rising edge
//   Reset  : synchronous, active-high
//   bus    : inst_mem_if.slave (load stream, load status, fetch port)
module inst_mem #(
    parameter int            A         = 10,
    parameter int            W         = 9,
    parameter logic [W-1:0]  HALT_WORD = {W{1'b1}}
) (
    input  logic          Clk,
    input  logic          Reset,
    inst_mem_if.slave     bus
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] READY = 2'd2;

    localparam int DEPTH = 1 << A;

    logic [1:0]   state;
    logic [A-1:0] ptr;
    logic [A:0]   count;
    logic         err;
    logic [W-1:0] inst_out;
    logic         inst_valid;

    logic [W-1:0] mem [DEPTH];

    logic         accept;
    logic         at_top;
    logic [A:0]   ptr_next;

    // LoadStart always wins, so a word presented with it is never written.
    assign accept   = (state == LOAD) && bus.LoadValid && !bus.LoadStart;
    assign at_top   = (ptr == {A{1'b1}});
    // Computed at A+1 bits so the last slot yields a count of exactly 2**A.
    assign ptr_next = {1'b0, ptr} + {{A{1'b0}}, 1'b1};

    // Array is deliberately not reset; LoadCount masks stale contents.
    always_ff @(posedge Clk) begin
        if (!Reset && accept) begin
            mem[ptr] <= bus.LoadData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= IDLE;
            ptr        <= '0;
            count      <= '0;
            err        <= 1'b0;
            inst_out   <= HALT_WORD;
            inst_valid <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (state == READY && bus.FetchEn) begin
                inst_valid <= 1'b1;
                if ({1'b0, bus.InstAddress} < count) begin
                    inst_out <= mem[bus.InstAddress];
                end else begin
                    inst_out <= HALT_WORD;
                end
            end

            if (bus.LoadStart) begin
                state <= LOAD;
                ptr   <= '0;
                count <= '0;
                err   <= 1'b0;
            end else if (accept) begin
                ptr <= ptr_next[A-1:0];
                if (bus.LoadLast) begin
                    state <= READY;
                    count <= ptr_next;
                end else if (at_top) begin
                    // Memory full without a terminating word: finish anyway
                    // and flag it.
                    state <= READY;
                    count <= ptr_next;
                    err   <= 1'b1;
                end
            end
        end
    end

    // Status is decoded from registers only; no input-to-output paths.
    assign bus.LoadReady = (state == LOAD);
    assign bus.Loaded    = (state == READY);
    assign bus.LoadCount = count;
    assign bus.LoadErr   = err;
    assign bus.InstOut   = inst_out;
    assign bus.InstValid = inst_valid;
endmodule

// File: tb/tb_inst_mem.sv
// tb/tb_inst_mem.sv - scoreboard testbench for inst_mem
module tb_inst_mem;
    logic Clk;
    logic Reset;

    inst_mem_if #(.A(10), .W(9)) m ();
    inst_mem_if #(.A(3),  .W(9)) s ();

    inst_mem #(.A(10), .W(9)) dut (.Clk(Clk), .Reset(Reset), .bus(m.slave));
    inst_mem #(.A(3),  .W(9)) dut_small (.Clk(Clk), .Reset(Reset), .bus(s.slave));

    int passed = 0;
    int total  = 0;
    logic [8:0] exp_q [$];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Fetch-result monitor for the A=10 instance.
    always @(negedge Clk) begin
        if (!Reset && m.InstValid) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_instvalid: got 1 expected 0");
            end else begin
                chk("fetch_data", {23'd0, m.InstOut}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr();
        m.LoadStart = 0; m.LoadValid = 0; m.LoadData = '0; m.LoadLast = 0;
        m.FetchEn = 0; m.InstAddress = '0;
        s.LoadStart = 0; s.LoadValid = 0; s.LoadData = '0; s.LoadLast = 0;
        s.FetchEn = 0; s.InstAddress = '0;
    endtask

    task automatic m_start();
        m.LoadStart = 1; tick(); m.LoadStart = 0;
    endtask

    task automatic m_word(input logic [8:0] d, input logic last);
        m.LoadValid = 1; m.LoadData = d; m.LoadLast = last;
        tick();
        m.LoadValid = 0; m.LoadLast = 0;
    endtask

    task automatic m_fetch(input logic [9:0] a, input logic [8:0] e);
        m.FetchEn = 1; m.InstAddress = a; exp_q.push_back(e);
        tick();
        m.FetchEn = 0;
    endtask

    task automatic s_word(input logic [8:0] d, input logic last);
        s.LoadValid = 1; s.LoadData = d; s.LoadLast = last;
        tick();
        s.LoadValid = 0; s.LoadLast = 0;
    endtask

    logic [8:0] prog [5];

    initial begin
        prog[0] = 9'b000_001_100;
        prog[1] = 9'b000_101_000;
        prog[2] = 9'b010_101_010;
        prog[3] = 9'b001_001_100;
        prog[4] = 9'h1FF;
        clr();
        Reset = 1;
        tick(); tick();
        Reset = 0;
        chk("rst_loadready", {31'd0, m.LoadReady}, 0);
        chk("rst_loaded",    {31'd0, m.Loaded}, 0);
        chk("rst_loadcount", {21'd0, m.LoadCount}, 0);
        chk("rst_loaderr",   {31'd0, m.LoadErr}, 0);
        chk("rst_instout",   {23'd0, m.InstOut}, 32'h1FF);
        chk("rst_instvalid", {31'd0, m.InstValid}, 0);

        // FetchEn in IDLE gives no result.
        m.FetchEn = 1; tick(); m.FetchEn = 0;
        chk("idle_fetch_valid", {31'd0, m.InstValid}, 0);

        // Five-word program.
        m_start();
        chk("load_ready", {31'd0, m.LoadReady}, 1);
        for (int i = 0; i < 5; i++) m_word(prog[i], i == 4);
        chk("p5_count",  {21'd0, m.LoadCount}, 5);
        chk("p5_loaded", {31'd0, m.Loaded}, 1);
        chk("p5_ready",  {31'd0, m.LoadReady}, 0);
        for (int i = 0; i < 5; i++) begin
            m_fetch(10'(i), prog[i]);
            chk("b2b_valid", {31'd0, m.InstValid}, 1);
        end
        m_fetch(10'd7, 9'h1FF);
        m_fetch(10'd3, 9'b001_001_100);
        tick();

        // Gapped load with a fetch attempt during LOAD.
        m_start();
        m_word(9'h011, 0);
        m.FetchEn = 1; m.InstAddress = 10'd0; tick(); m.FetchEn = 0;
        chk("load_fetch_valid", {31'd0, m.InstValid}, 0);
        m_word(9'h022, 0);
        tick();
        m_word(9'h033, 1);
        chk("gap_count", {21'd0, m.LoadCount}, 3);
        m_fetch(10'd0, 9'h011);
        m_fetch(10'd1, 9'h022);
        m_fetch(10'd2, 9'h033);
        m_fetch(10'd3, 9'h1FF);
        tick();

        // Reset in the middle of a load.
        m_start();
        m_word(9'h101, 0);
        m_word(9'h102, 0);
        Reset = 1; tick(); Reset = 0;
        chk("midrst_count",  {21'd0, m.LoadCount}, 0);
        chk("midrst_loaded", {31'd0, m.Loaded}, 0);
        chk("midrst_ready",  {31'd0, m.LoadReady}, 0);
        m_start();
        m_word(9'h0AA, 1);
        m_fetch(10'd0, 9'h0AA);
        m_fetch(10'd1, 9'h1FF);
        tick();

        // LoadStart with LoadValid in READY, then again in LOAD.
        m.LoadStart = 1; m.LoadValid = 1; m.LoadData = 9'h155; tick();
        m.LoadStart = 0; m.LoadValid = 0;
        chk("rs_ready",  {31'd0, m.LoadReady}, 1);
        chk("rs_count",  {21'd0, m.LoadCount}, 0);
        m.LoadStart = 1; m.LoadValid = 1; m.LoadData = 9'h166; tick();
        m.LoadStart = 0; m.LoadValid = 0;
        chk("rl_ready",  {31'd0, m.LoadReady}, 1);
        m_word(9'h077, 1);
        chk("rl_count",  {21'd0, m.LoadCount}, 1);
        // LoadValid in READY is ignored.
        m_word(9'h1AB, 1);
        chk("ready_valid_count", {21'd0, m.LoadCount}, 1);
        m_fetch(10'd0, 9'h077);
        m_fetch(10'd1, 9'h1FF);
        tick(); tick();
        chk("scoreboard_empty", exp_q.size(), 0);

        // A=3 instance: fill without LoadLast.
        s.LoadStart = 1; tick(); s.LoadStart = 0;
        for (int i = 1; i <= 8; i++) s_word(9'(i), 0);
        chk("fill_err",    {31'd0, s.LoadErr}, 1);
        chk("fill_count",  {28'd0, s.LoadCount}, 8);
        chk("fill_loaded", {31'd0, s.Loaded}, 1);
        chk("fill_ready",  {31'd0, s.LoadReady}, 0);
        s.FetchEn = 1; s.InstAddress = 3'd7; tick(); s.FetchEn = 0;
        chk("fill_fetch7_valid", {31'd0, s.InstValid}, 1);
        chk("fill_fetch7_data",  {23'd0, s.InstOut}, 32'h008);
        tick();
        chk("fill_err_sticky", {31'd0, s.LoadErr}, 1);
        s.LoadStart = 1; tick(); s.LoadStart = 0;
        chk("restart_err", {31'd0, s.LoadErr}, 0);
        // Fill with LoadLast on the final slot completes cleanly.
        for (int i = 1; i <= 8; i++) s_word(9'(i + 16), i == 8);
        chk("full_last_err",   {31'd0, s.LoadErr}, 0);
        chk("full_last_count", {28'd0, s.LoadCount}, 8);
        s.FetchEn = 1; s.InstAddress = 3'd0; tick(); s.FetchEn = 0;
        chk("full_last_fetch0", {23'd0, s.InstOut}, 32'h011);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
